// File: rtl/rs_tdp36k_pkg.sv
// Shared constants for the rs_tdp36k block-RAM model: width codes, flag indices,
// MODE_BITS field offsets and FIFO depths.
package rs_tdp36k_pkg;

  typedef enum logic {HalfRam = 1'b0, HalfFifo = 1'b1} half_mode_e;

  localparam logic [2:0] WidthW18 = 3'b010;
  localparam logic [2:0] WidthW9  = 3'b100;

  localparam int unsigned FlagOvf    = 0;
  localparam int unsigned FlagPfull  = 1;
  localparam int unsigned FlagAfull  = 2;
  localparam int unsigned FlagFull   = 3;
  localparam int unsigned FlagUdf    = 4;
  localparam int unsigned FlagPempty = 5;
  localparam int unsigned FlagAempty = 6;
  localparam int unsigned FlagEmpty  = 7;

  localparam int unsigned Wrw1Lsb    = 68;
  localparam int unsigned FifoEn1Bit = 67;
  localparam int unsigned Pe1Lsb     = 53;
  localparam int unsigned Pf1Lsb     = 41;
  localparam int unsigned Wrw2Lsb    = 27;
  localparam int unsigned FifoEn2Bit = 26;
  localparam int unsigned Pe2Lsb     = 12;
  localparam int unsigned Pf2Lsb     = 1;

  localparam int unsigned CntW     = 12;
  localparam int unsigned RamWords = 1024;
  localparam logic [CntW-1:0] DepthW18 = 12'd1024;
  localparam logic [CntW-1:0] DepthW9  = 12'd2048;

  // 9-bit lane of an 18-bit word presented in lane0 position: {bit16, bits7:0}.
  function automatic logic [17:0] narrow_read(logic [17:0] word, logic upper);
    return upper ? {1'b0, word[17], 8'h00, word[15:8]} : {1'b0, word[16], 8'h00, word[7:0]};
  endfunction

endpackage

// File: rtl/rs_tdp36k_if.sv
// Per-half port bundle of rs_tdp36k. Half 2 only drives addr[13:0]; bit 14 is ignored.
interface rs_tdp36k_if;
  logic        flush;
  logic        wen_a;
  logic        wen_b;
  logic        ren_a;
  logic        ren_b;
  logic [1:0]  be_a;
  logic [1:0]  be_b;
  logic [14:0] addr_a;
  logic [14:0] addr_b;
  logic [17:0] wdata_a;
  logic [17:0] wdata_b;
  logic [17:0] rdata_a;
  logic [17:0] rdata_b;

  modport master (
    output flush, wen_a, wen_b, ren_a, ren_b, be_a, be_b, addr_a, addr_b, wdata_a, wdata_b,
    input  rdata_a, rdata_b
  );
  modport slave (
    input  flush, wen_a, wen_b, ren_a, ren_b, be_a, be_b, addr_a, addr_b, wdata_a, wdata_b,
    output rdata_a, rdata_b
  );
endinterface

// File: rtl/rs_tdp36k_half.sv
// One 18Kb half: true-dual-port RAM or FIFO with flags. RS_TDP36K_RDATA_OUTREG_EN adds an
// output register on read data (not on the flag word).
module rs_tdp36k_half
  import rs_tdp36k_pkg::*;
#(
  parameter half_mode_e  Mode     = HalfRam,
  parameter logic [2:0]  Wrw      = WidthW18,
  parameter logic [10:0] PeThresh = '0,
  parameter logic [10:0] PfThresh = '0
) (
  input logic        clk_i,
  input logic        rst_ni,
  rs_tdp36k_if.slave bus
);
  localparam bit IsFifo = (Mode == HalfFifo);
  localparam bit Narrow = IsFifo && (Wrw == WidthW9);
  localparam logic [CntW-1:0] Depth = Narrow ? DepthW9 : DepthW18;

  logic [17:0]     mem [RamWords];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [10:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic            ovf_q, ovf_d, udf_q, udf_d;
  logic [17:0]     rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic [17:0]     rdata_a_out, rdata_b_out, flags, pop_word;
  logic            wa_en, wb_en, full, empty, push_ok, pop_ok, flushing;
  logic [9:0]      wa_addr, wb_addr, rb_addr;
  logic [1:0]      wa_be, wb_be;
  logic [17:0]     wa_data, wb_data;
  logic            unused_addr;

  assign unused_addr = ^{bus.addr_a[14], bus.addr_a[3:0], bus.addr_b[14], bus.addr_b[3:0]};

  assign full     = (cnt_q == Depth);
  assign empty    = (cnt_q == '0);
  assign push_ok  = bus.wen_a && !full;
  assign pop_ok   = bus.ren_b && !empty;
  assign flushing = !bus.flush;

  // Map FIFO or RAM traffic onto the two physical write ports and the B read port.
  always_comb begin
    wa_en   = 1'b0;
    wa_addr = '0;
    wa_be   = '0;
    wa_data = '0;
    wb_en   = 1'b0;
    wb_addr = bus.addr_b[13:4];
    wb_be   = bus.be_b;
    wb_data = bus.wdata_b;
    rb_addr = bus.addr_b[13:4];
    if (IsFifo) begin
      wa_en = push_ok && !flushing;
      if (Narrow) begin
        wa_addr = wptr_q[10:1];
        wa_be   = wptr_q[0] ? 2'b10 : 2'b01;
        wa_data = {bus.wdata_a[8], bus.wdata_a[8], bus.wdata_a[7:0], bus.wdata_a[7:0]};
        rb_addr = rptr_q[10:1];
      end else begin
        wa_addr = wptr_q[9:0];
        wa_be   = 2'b11;
        wa_data = bus.wdata_a;
        rb_addr = rptr_q[9:0];
      end
    end else begin
      wa_en   = bus.wen_a;
      wa_addr = bus.addr_a[13:4];
      wa_be   = bus.be_a;
      wa_data = bus.wdata_a;
      wb_en   = bus.wen_b;
    end
  end

  // Port A is written last so it wins an address collision.
  always_ff @(posedge clk_i) begin
    if (wb_en && wb_be[0]) begin
      mem[wb_addr][16]  <= wb_data[16];
      mem[wb_addr][7:0] <= wb_data[7:0];
    end
    if (wb_en && wb_be[1]) begin
      mem[wb_addr][17]   <= wb_data[17];
      mem[wb_addr][15:8] <= wb_data[15:8];
    end
    if (wa_en && wa_be[0]) begin
      mem[wa_addr][16]  <= wa_data[16];
      mem[wa_addr][7:0] <= wa_data[7:0];
    end
    if (wa_en && wa_be[1]) begin
      mem[wa_addr][17]   <= wa_data[17];
      mem[wa_addr][15:8] <= wa_data[15:8];
    end
  end

  assign pop_word = mem[rb_addr];

  always_comb begin
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (IsFifo) begin
      if (flushing) begin
        cnt_d  = '0;
        wptr_d = '0;
        rptr_d = '0;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q + {11'd0, push_ok} - {11'd0, pop_ok};
        wptr_d = wptr_q + {10'd0, push_ok};
        rptr_d = rptr_q + {10'd0, pop_ok};
        ovf_d  = bus.wen_a && full;
        udf_d  = bus.ren_b && empty;
        if (pop_ok) rdata_b_d = Narrow ? narrow_read(pop_word, rptr_q[0]) : pop_word;
      end
    end else begin
      if (bus.ren_a) rdata_a_d = mem[bus.addr_a[13:4]];
      if (bus.ren_b) rdata_b_d = pop_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  always_comb begin
    flags             = '0;
    flags[FlagOvf]    = ovf_q;
    flags[FlagPfull]  = (cnt_q >= {1'b0, PfThresh});
    flags[FlagAfull]  = (cnt_q == Depth - 12'd1);
    flags[FlagFull]   = full;
    flags[FlagUdf]    = udf_q;
    flags[FlagPempty] = (cnt_q <= {1'b0, PeThresh});
    flags[FlagAempty] = (cnt_q == 12'd1);
    flags[FlagEmpty]  = empty;
  end

`ifdef RS_TDP36K_RDATA_OUTREG_EN
  logic [17:0] rdata_a_oq, rdata_b_oq;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_a_oq <= '0;
      rdata_b_oq <= '0;
    end else begin
      rdata_a_oq <= rdata_a_q;
      rdata_b_oq <= rdata_b_q;
    end
  end
  assign rdata_a_out = rdata_a_oq;
  assign rdata_b_out = rdata_b_oq;
`else
  assign rdata_a_out = rdata_a_q;
  assign rdata_b_out = rdata_b_q;
`endif

  assign bus.rdata_a = IsFifo ? flags : rdata_a_out;
  assign bus.rdata_b = rdata_b_out;

endmodule

// File: rtl/rs_tdp36k.sv
// 36Kb block-RAM model: two independent 18Kb halves configured from MODE_BITS.
// Optional macro RS_TDP36K_RDATA_OUTREG_EN: extra read-data output register (latency 2).
module rs_tdp36k
  import rs_tdp36k_pkg::*;
#(
  parameter logic [80:0] MODE_BITS = 81'd0
) (
  input logic        CLK,
  input logic        RESET,
  rs_tdp36k_if.slave port1,
  rs_tdp36k_if.slave port2
);
  localparam half_mode_e Mode1 = half_mode_e'(MODE_BITS[FifoEn1Bit]);
  localparam half_mode_e Mode2 = half_mode_e'(MODE_BITS[FifoEn2Bit]);

  // Only the lower 3 bits of each width field matter; type and read-width fields are ignored.
  rs_tdp36k_half #(
    .Mode    (Mode1),
    .Wrw     (MODE_BITS[Wrw1Lsb +: 3]),
    .PeThresh(MODE_BITS[Pe1Lsb +: 11]),
    .PfThresh(MODE_BITS[Pf1Lsb +: 11])
  ) u_half1 (
    .clk_i (CLK),
    .rst_ni(RESET),
    .bus   (port1)
  );

  rs_tdp36k_half #(
    .Mode    (Mode2),
    .Wrw     (MODE_BITS[Wrw2Lsb +: 3]),
    .PeThresh(MODE_BITS[Pe2Lsb +: 11]),
    .PfThresh(MODE_BITS[Pf2Lsb +: 11])
  ) u_half2 (
    .clk_i (CLK),
    .rst_ni(RESET),
    .bus   (port2)
  );

endmodule

// File: tb/tb_rs_tdp36k.sv
// Bench for rs_tdp36k: one instance with FIFO18 + FIFO9 halves, one with two RAM halves,
// checked every cycle against a queue/array model plus hand-computed literals.
module tb_rs_tdp36k;

  localparam logic [80:0] ModeF = (81'd2 << 68) | (81'd1 << 67) | (81'd4 << 53) |
                                  (81'd1018 << 41) | (81'd4 << 27) | (81'd1 << 26) |
                                  (81'd4 << 12) | (81'd2040 << 1);
  localparam logic [80:0] ModeR = 81'd0;
`ifdef RS_TDP36K_RDATA_OUTREG_EN
  localparam bit OutReg = 1'b1;
`else
  localparam bit OutReg = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_tdp36k_if f1 ();
  rs_tdp36k_if f2 ();
  rs_tdp36k_if r1 ();
  rs_tdp36k_if r2 ();

  rs_tdp36k #(.MODE_BITS(ModeF)) dut_f (.CLK(clk), .RESET(rst_n), .port1(f1), .port2(f2));
  rs_tdp36k #(.MODE_BITS(ModeR)) dut_r (.CLK(clk), .RESET(rst_n), .port1(r1), .port2(r2));

  int checks = 0;
  int failures = 0;

  // FIFO model: circular array + occupancy count per FIFO (0: 18-bit, 1: 9-bit).
  int          fdep [2] = '{1024, 2048};
  int          fpe  [2] = '{4, 4};
  int          fpf  [2] = '{1018, 2040};
  int          fcnt [2];
  int          fhead[2];
  logic [17:0] fst  [2][2048];
  logic        fovf [2];
  logic        fudf [2];
  logic [17:0] frb  [2];
  logic [17:0] frb_o[2];
  // RAM model for r1.
  logic [17:0] rm [1024];
  logic [17:0] rra, rrb, rra_o, rrb_o;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] fflags(int k);
    logic [17:0] f = '0;
    f[0] = fovf[k];
    f[1] = fcnt[k] >= fpf[k];
    f[2] = fcnt[k] == fdep[k] - 1;
    f[3] = fcnt[k] == fdep[k];
    f[4] = fudf[k];
    f[5] = fcnt[k] <= fpe[k];
    f[6] = fcnt[k] == 1;
    f[7] = fcnt[k] == 0;
    return f;
  endfunction

  function automatic logic [17:0] merge(logic [17:0] old, logic [17:0] nw, logic [1:0] be);
    logic [17:0] r = old;
    if (be[0]) begin r[16] = nw[16]; r[7:0] = nw[7:0]; end
    if (be[1]) begin r[17] = nw[17]; r[15:8] = nw[15:8]; end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      fcnt[k] = 0; fhead[k] = 0; fovf[k] = 1'b0; fudf[k] = 1'b0;
      frb[k] = '0; frb_o[k] = '0;
    end
    rra = '0; rrb = '0; rra_o = '0; rrb_o = '0;
  endtask

  task automatic model_step();
    logic psh, pp, fl, full, empty;
    logic [17:0] wd;
    for (int k = 0; k < 2; k++) begin
      psh = (k == 0) ? f1.wen_a : f2.wen_a;
      pp  = (k == 0) ? f1.ren_b : f2.ren_b;
      fl  = (k == 0) ? f1.flush : f2.flush;
      wd  = (k == 0) ? f1.wdata_a : f2.wdata_a;
      frb_o[k] = frb[k];
      if (!fl) begin
        fcnt[k] = 0; fhead[k] = 0; fovf[k] = 1'b0; fudf[k] = 1'b0;
      end else begin
        full  = (fcnt[k] == fdep[k]);
        empty = (fcnt[k] == 0);
        fovf[k] = psh && full;
        fudf[k] = pp && empty;
        if (pp && !empty) begin
          frb[k] = fst[k][fhead[k]];
          fhead[k] = (fhead[k] + 1) % fdep[k];
          fcnt[k]--;
        end
        if (psh && !full) begin
          fst[k][(fhead[k] + fcnt[k]) % fdep[k]] = (k == 0) ? wd :
                                                   {1'b0, wd[8], 8'h00, wd[7:0]};
          fcnt[k]++;
        end
      end
    end
    rra_o = rra;
    rrb_o = rrb;
    if (r1.ren_a) rra = rm[r1.addr_a[13:4]];
    if (r1.ren_b) rrb = rm[r1.addr_b[13:4]];
    if (r1.wen_b) rm[r1.addr_b[13:4]] = merge(rm[r1.addr_b[13:4]], r1.wdata_b, r1.be_b);
    if (r1.wen_a) rm[r1.addr_a[13:4]] = merge(rm[r1.addr_a[13:4]], r1.wdata_a, r1.be_a);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_bus();
    f1.flush = 1'b1; f1.wen_a = 0; f1.wen_b = 0; f1.ren_a = 0; f1.ren_b = 0;
    f1.be_a = 0; f1.be_b = 0; f1.addr_a = 0; f1.addr_b = 0; f1.wdata_a = 0; f1.wdata_b = 0;
    f2.flush = 1'b1; f2.wen_a = 0; f2.wen_b = 0; f2.ren_a = 0; f2.ren_b = 0;
    f2.be_a = 0; f2.be_b = 0; f2.addr_a = 0; f2.addr_b = 0; f2.wdata_a = 0; f2.wdata_b = 0;
    r1.flush = 1'b1; r1.wen_a = 0; r1.wen_b = 0; r1.ren_a = 0; r1.ren_b = 0;
    r1.be_a = 0; r1.be_b = 0; r1.addr_a = 0; r1.addr_b = 0; r1.wdata_a = 0; r1.wdata_b = 0;
    r2.flush = 1'b1; r2.wen_a = 0; r2.wen_b = 0; r2.ren_a = 0; r2.ren_b = 0;
    r2.be_a = 0; r2.be_b = 0; r2.addr_a = 0; r2.addr_b = 0; r2.wdata_a = 0; r2.wdata_b = 0;
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("f1_flags", f1.rdata_a, fflags(0));
      check("f1_rdata_b", f1.rdata_b, OutReg ? frb_o[0] : frb[0]);
      check("f2_flags", f2.rdata_a, fflags(1));
      check("f2_rdata_b", f2.rdata_b, OutReg ? frb_o[1] : frb[1]);
      check("r1_rdata_a", r1.rdata_a, OutReg ? rra_o : rra);
      check("r1_rdata_b", r1.rdata_b, OutReg ? rrb_o : rrb);
      check("r2_rdata_a", r2.rdata_a, 18'h0);
      check("r2_rdata_b", r2.rdata_b, 18'h0);
    end
  end

  logic [17:0] vals [3] = '{18'h3FFFF, 18'h00001, 18'h2A5A5};

  initial begin
    clear_bus();
    model_reset();
    idle(3);
    rst_n = 1'b1;
    tick();
    check("reset_flags", f1.rdata_a & 18'h0DF, 18'h080);

    // FIFO 18-bit ordering
    for (int i = 0; i < 3; i++) begin
      f1.wen_a = 1'b1; f1.wdata_a = vals[i]; tick();
    end
    f1.wen_a = 1'b0;
    idle(3);
    check("three_words_flags", f1.rdata_a, 18'h020);
    for (int i = 0; i < 3; i++) begin
      f1.ren_b = 1'b1; tick(); f1.ren_b = 1'b0;
      idle(3);
      check("pop_order", f1.rdata_b, vals[i]);
    end

    // Fill to full
    f1.wen_a = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      f1.wdata_a = 18'(i);
      tick();
      if (i == 1017) check("prog_full_1018", f1.rdata_a, 18'h002);
      if (i == 1022) check("almost_full_1023", f1.rdata_a, 18'h006);
    end
    f1.wen_a = 1'b0;
    check("full_1024", f1.rdata_a, 18'h00A);
    f1.wen_a = 1'b1; f1.wdata_a = 18'h15555; tick(); f1.wen_a = 1'b0;
    check("overflow_pulse", f1.rdata_a, 18'h00B);
    tick();
    check("overflow_clears", f1.rdata_a, 18'h00A);
    f1.wen_a = 1'b1; f1.ren_b = 1'b1; tick(); f1.wen_a = 1'b0; f1.ren_b = 1'b0;
    check("full_push_pop", f1.rdata_a, 18'h007);

    // Drain, then pop on empty
    f1.ren_b = 1'b1;
    for (int i = 0; i < 1023; i++) tick();
    f1.ren_b = 1'b0;
    tick();
    f1.ren_b = 1'b1; tick(); f1.ren_b = 1'b0;
    check("underflow_pulse", f1.rdata_a, 18'h0B0);
    idle(3);
    check("underflow_hold", f1.rdata_b, 18'h003FF);
    check("underflow_clears", f1.rdata_a, 18'h0A0);

    // Reset in the middle of traffic
    f1.wen_a = 1'b1; f1.wdata_a = 18'h00777; idle(2);
    rst_n = 1'b0; model_reset();
    tick();
    check("midreset_flags", f1.rdata_a & 18'h0DF, 18'h080);
    check("midreset_rdata_b", f1.rdata_b, 18'h0);
    f1.wen_a = 1'b0; rst_n = 1'b1;
    tick();

    // Flush
    f1.wen_a = 1'b1; idle(3); f1.wen_a = 1'b0;
    f1.flush = 1'b0; tick(); f1.flush = 1'b1;
    check("flush_empty", f1.rdata_a, 18'h0A0);

    // FIFO 9-bit
    f2.wen_a = 1'b1; f2.wdata_a = 18'h001FF; tick();
    f2.wdata_a = 18'h000AA; tick(); f2.wen_a = 1'b0;
    f2.ren_b = 1'b1; tick(); f2.ren_b = 1'b0; idle(3);
    check("w9_pop0", f2.rdata_b, 18'h100FF);
    f2.ren_b = 1'b1; tick(); f2.ren_b = 1'b0; idle(3);
    check("w9_pop1", f2.rdata_b, 18'h000AA);
    f2.wen_a = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      f2.wdata_a = 18'(i * 7 + 3);
      tick();
      if (i == 2046) check("w9_almost_full", f2.rdata_a, 18'h006);
    end
    f2.wen_a = 1'b0;
    check("w9_full", f2.rdata_a, 18'h00A);
    f2.ren_b = 1'b1; idle(3); f2.ren_b = 1'b0; idle(3);

    // RAM: byte lanes, read-during-write, collision, ignored address bits
    r1.wen_a = 1'b1; r1.be_a = 2'b11; r1.addr_a = 15'(5 << 4); r1.wdata_a = 18'h3FFFF; tick();
    r1.be_a = 2'b01; r1.wdata_a = 18'h12345; tick(); r1.wen_a = 1'b0;
    r1.ren_b = 1'b1; r1.addr_b = 15'(5 << 4); tick(); r1.ren_b = 1'b0; idle(3);
    check("ram_lane0", r1.rdata_b, 18'h3FF45);
    r1.wen_a = 1'b1; r1.ren_a = 1'b1; r1.be_a = 2'b11; r1.wdata_a = 18'h00ABC; tick();
    r1.wen_a = 1'b0; r1.ren_a = 1'b0; idle(3);
    check("ram_rdw_old", r1.rdata_a, 18'h3FF45);
    r1.ren_a = 1'b1; tick(); r1.ren_a = 1'b0; idle(3);
    check("ram_rdw_new", r1.rdata_a, 18'h00ABC);
    r1.wen_a = 1'b1; r1.wen_b = 1'b1; r1.be_b = 2'b11;
    r1.addr_a = 15'(7 << 4); r1.addr_b = 15'(7 << 4);
    r1.wdata_a = 18'h11111; r1.wdata_b = 18'h22222; tick();
    r1.wen_a = 1'b0; r1.wen_b = 1'b0;
    r1.ren_b = 1'b1; tick(); r1.ren_b = 1'b0; idle(3);
    check("ram_collision", r1.rdata_b, 18'h11111);
    r1.wen_b = 1'b1; r1.addr_b = 15'(9 << 4); r1.wdata_b = 18'h0; tick();
    r1.be_b = 2'b10; r1.addr_b = 15'h4000 | 15'(9 << 4) | 15'hF; r1.wdata_b = 18'h3FFFF; tick();
    r1.wen_b = 1'b0; r1.ren_b = 1'b1; tick(); r1.ren_b = 1'b0; idle(3);
    check("ram_lane1", r1.rdata_b, 18'h2FF00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
